// File: rtl/eccop_pkg.sv
// rtl/eccop_pkg.sv - shared op codes, ALU select words and sequencer state encoding
package eccop_pkg;

    // Modular operations accepted by the sequencer; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        OP_MADD = 3'd0,
        OP_MSUB = 3'd1,
        OP_MDBL = 3'd2,
        OP_MHLV = 3'd3,
        OP_MRED = 3'd4,
        OP_LDP  = 3'd5
    } op_t;

    // ALU function select words.
    localparam logic [6:0] S_ADD      = 7'b0000000;
    localparam logic [6:0] S_2W_B     = 7'b0000001;
    localparam logic [6:0] S_SUB      = 7'b0000010;
    localparam logic [6:0] S_COND_SUB = 7'b0011000;
    localparam logic [6:0] S_LOAD_P   = 7'b0101000;
    localparam logic [6:0] S_PASS_W   = 7'b0101010;
    localparam logic [6:0] S_SHR      = 7'b1001001;

    // Sequencer states: two ALU passes then a one-cycle done.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/eccop_alu.sv
// rtl/eccop_alu.sv - combinational modular-arithmetic ALU step (add/sub/double/shift/load)
module eccop_alu
    import eccop_pkg::*;
#(
    parameter int P_WIDTH = 260
) (
    input  logic [6:0]         s,
    input  logic [P_WIDTH-1:0] w,
    input  logic [P_WIDTH-1:0] b,
    input  logic [P_WIDTH-1:0] p,
    input  logic               m,
    output logic [P_WIDTH-1:0] q,
    output logic               carry
);

    logic [P_WIDTH:0] sum;
    logic [P_WIDTH:0] dif;
    logic [P_WIDTH:0] dbl;
    logic [P_WIDTH:0] cin;

    // Candidate results; m acts as carry-in (add) or borrow-in (sub), bit P_WIDTH is carry/borrow.
    always_comb begin
        cin = {{P_WIDTH{1'b0}}, m};
        sum = {1'b0, w} + {1'b0, b} + cin;
        dif = {1'b0, w} - {1'b0, b} - cin;
        dbl = {w, 1'b0} + {1'b0, b} + cin;
    end

    // Select the function; conditional subtract keeps w when w - b would borrow.
    always_comb begin
        q     = '0;
        carry = 1'b0;
        case (s)
            S_ADD:      {carry, q} = sum;
            S_2W_B:     {carry, q} = dbl;
            S_SUB:      {carry, q} = dif;
            S_COND_SUB: begin
                carry = dif[P_WIDTH];
                q     = dif[P_WIDTH] ? w : dif[P_WIDTH-1:0];
            end
            S_LOAD_P:   q = p;
            S_PASS_W:   q = w;
            S_SHR: begin
                q     = {1'b0, w[P_WIDTH-1:1]};
                carry = w[0];
            end
            default: begin
                q     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/eccop_alu_seq.sv
// rtl/eccop_alu_seq.sv - fixed-latency sequencer running one modular op on eccop_alu (option: ECCOP_SEQ_OPCHK_EN)
module eccop_alu_seq
    import eccop_pkg::*;
#(
    parameter int P_WIDTH = 260
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    input  logic [P_WIDTH-1:0] p,
    output logic               busy,
    output logic               done,
    output logic [P_WIDTH-1:0] r,
    output logic               zero,
    output logic               err
);

    state_t             state;
    state_t             next_state;
    logic               accept;
    logic [2:0]         op_r;
    logic [P_WIDTH-1:0] a_r;
    logic [P_WIDTH-1:0] b_r;
    logic [P_WIDTH-1:0] p_r;
    logic [P_WIDTH-1:0] acc;
    logic               cy;
    logic [P_WIDTH-1:0] r_q;
    logic [P_WIDTH-1:0] res;

    logic [6:0]         alu_s;
    logic [P_WIDTH-1:0] alu_w;
    logic [P_WIDTH-1:0] alu_b;
    logic [P_WIDTH-1:0] alu_q;
    logic               alu_carry;

    assign accept = start && (state == ST_IDLE);

    // State register; reset aborts any op in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: every op walks the same S1 -> S2 -> DONE path.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = ST_S1;
            ST_S1:   next_state = ST_S2;
            ST_S2:   next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // ALU drive: S1 works on the sampled operands, S2 finishes on the accumulator.
    always_comb begin
        alu_s = S_PASS_W;
        alu_w = acc;
        alu_b = '0;
        if (state == ST_S1) begin
            case (op_r)
                OP_MADD: begin alu_s = S_ADD;      alu_w = a_r; alu_b = b_r; end
                OP_MSUB: begin alu_s = S_SUB;      alu_w = a_r; alu_b = b_r; end
                OP_MDBL: begin alu_s = S_2W_B;     alu_w = a_r; alu_b = '0;  end
                OP_MHLV: begin alu_s = S_ADD;      alu_w = a_r; alu_b = a_r[0] ? p_r : '0; end
                OP_MRED: begin alu_s = S_COND_SUB; alu_w = a_r; alu_b = p_r; end
                default: begin alu_s = S_LOAD_P;   alu_w = a_r; alu_b = '0;  end
            endcase
        end else if (state == ST_S2) begin
            case (op_r)
                OP_MADD, OP_MDBL: begin alu_s = S_SUB; alu_b = p_r; end
                OP_MSUB:          begin alu_s = S_ADD; alu_b = cy ? p_r : '0; end
                OP_MHLV:          begin alu_s = S_SHR; end
                default:          begin alu_s = S_PASS_W; end
            endcase
        end
    end

    // Final result selection from the second ALU pass.
    always_comb begin
        case (op_r)
            // Subtract p only if the sum overflowed or the trial subtraction did not borrow.
            OP_MADD, OP_MDBL: res = (cy | ~alu_carry) ? alu_q : acc;
            // Halving an odd value shifted in the carry of a + p at the top bit.
            OP_MHLV:          res = alu_q | {cy, {(P_WIDTH-1){1'b0}}};
            default:          res = alu_q;
        endcase
    end

`ifdef ECCOP_SEQ_OPCHK_EN
    logic err_q;
    logic rsvd;

    assign rsvd = op_r[2] & op_r[1];
    assign err  = err_q;

    // Datapath registers with reserved-op flagging: err set at DONE, r left untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            p_r   <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            r_q   <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                op_r  <= op;
                a_r   <= a;
                b_r   <= b;
                p_r   <= p;
                err_q <= 1'b0;
            end
            if (state == ST_S1) begin
                acc <= alu_q;
                cy  <= alu_carry;
            end
            if (state == ST_S2) begin
                if (rsvd) begin
                    err_q <= 1'b1;
                end else begin
                    r_q <= res;
                end
            end
        end
    end
`else
    assign err = 1'b0;

    // Datapath registers: operands sampled on accept, acc/cy after S1, r after S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= '0;
            a_r  <= '0;
            b_r  <= '0;
            p_r  <= '0;
            acc  <= '0;
            cy   <= 1'b0;
            r_q  <= '0;
        end else begin
            if (accept) begin
                op_r <= op;
                a_r  <= a;
                b_r  <= b;
                p_r  <= p;
            end
            if (state == ST_S1) begin
                acc <= alu_q;
                cy  <= alu_carry;
            end
            if (state == ST_S2) begin
                r_q <= res;
            end
        end
    end
`endif

    assign r    = r_q;
    assign zero = (r_q == '0);

    eccop_alu #(
        .P_WIDTH(P_WIDTH)
    ) u_alu (
        .s     (alu_s),
        .w     (alu_w),
        .b     (alu_b),
        .p     (p_r),
        .m     (1'b0),
        .q     (alu_q),
        .carry (alu_carry)
    );

endmodule
